// File: rtl/iz_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one fixed-point datapath.
// Each accepted tick walks every neuron through the datapath once, then publishes the spike vector.
module iz_neuron_array #(
   parameter int N_NEURONS = 4,
   parameter int DATA_W    = 16,
   parameter int FRAC      = 6,
   parameter int STIM_W    = 8,
   parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
   parameter logic signed [DATA_W-1:0] V_THRESH = DATA_W'(30 * (2 ** FRAC)),
   parameter logic signed [DATA_W-1:0] V_REST   = DATA_W'(-70 * (2 ** FRAC))
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          enable_i,
   input  logic                          tick_i,
   input  logic [N_NEURONS*STIM_W-1:0]   stim_i,
   input  logic                          cfg_valid_i,
   output logic                          cfg_ready_o,
   input  logic [IDX_W-1:0]              cfg_idx_i,
   input  logic [1:0]                    cfg_sel_i,
   input  logic [DATA_W-1:0]             cfg_data_i,
   output logic                          params_ready_o,
   output logic                          busy_o,
   output logic                          step_done_o,
   output logic [N_NEURONS-1:0]          spike_vec_o,
   input  logic [IDX_W-1:0]              mon_sel_i,
   output logic [DATA_W-1:0]             mon_v_o,
   output logic                          overrun_o
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int IW    = 2 * DATA_W + 4;
   localparam logic signed [IW-1:0] K3    = IW'(3);
   localparam logic signed [IW-1:0] K5    = IW'(5);
   localparam logic signed [IW-1:0] K140  = IW'(140) <<< FRAC;
   localparam logic signed [IW-1:0] S_MAX = IW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [IW-1:0] S_MIN = -S_MAX - IW'(1);

   typedef logic signed [DATA_W-1:0] word_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        runIdx_q;
   logic [N_NEURONS*STIM_W-1:0] stim_q;
   word_t                   v_q [DEPTH];
   word_t                   u_q [DEPTH];
   word_t                   a_q [DEPTH];
   word_t                   b_q [DEPTH];
   word_t                   c_q [DEPTH];
   word_t                   d_q [DEPTH];
   logic [DEPTH-1:0][3:0]   mask_q;
   logic [DEPTH-1:0]        spikePend_q, spikeNext;
   logic [N_NEURONS-1:0]    spike_vec_q;
   logic                    overrun_q;
   word_t                   mon_v_q;

   logic [DEPTH-1:0]        idxOk;
   word_t                   vMon [DEPTH];
   logic                    paramsReady, tickAccept, cfgWrite, lastIdx, spkNow;
   word_t                   vCur, uCur, vNext, uNext;
   logic [STIM_W-1:0]       stimCur;
   logic signed [IW-1:0]    vX, uX, stimX, dv, du, bvs;

   function automatic word_t sat(input logic signed [IW-1:0] x);
      if (x > S_MAX) return word_t'(S_MAX);
      if (x < S_MIN) return word_t'(S_MIN);
      return x[DATA_W-1:0];
   endfunction

   // Slots beyond N_NEURONS exist only to make every index value legal; they are never valid.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      assign idxOk[g] = (g < N_NEURONS);
      assign vMon[g]  = (g < N_NEURONS) ? v_q[g] : '0;
   end

   always_comb begin
      paramsReady = 1'b1;
      for (int i = 0; i < N_NEURONS; i++) paramsReady = paramsReady & (&mask_q[i]);
   end

   assign cfg_ready_o    = (state_q == IDLE);
   assign params_ready_o = paramsReady;
   assign busy_o         = (state_q != IDLE);
   assign step_done_o    = (state_q == DONE);
   assign spike_vec_o    = spike_vec_q;
   assign overrun_o      = overrun_q;
   assign mon_v_o        = mon_v_q;

   // A tick only counts if the array was already fully configured before this cycle's write.
   assign tickAccept = (state_q == IDLE) && tick_i && enable_i && paramsReady;
   assign cfgWrite   = cfg_valid_i && (state_q == IDLE) && idxOk[cfg_idx_i];
   assign lastIdx    = (runIdx_q == IDX_W'(N_NEURONS - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tickAccept) state_d = RUN;
         RUN:     if (lastIdx) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Shared datapath: all intermediates are wide so only the final results need clamping.
   always_comb begin
      vCur    = v_q[runIdx_q];
      uCur    = u_q[runIdx_q];
      stimCur = stim_q[runIdx_q*STIM_W +: STIM_W];
      vX      = IW'(vCur);
      uX      = IW'(uCur);
      stimX   = {{(IW-STIM_W){1'b0}}, stimCur};
      spkNow  = (vCur >= V_THRESH);
      dv      = K3 * ((vX * vX) >>> 10) + K5 * vX + K140 + (stimX <<< FRAC) - uX;
      bvs     = ((IW'(b_q[runIdx_q]) * vX) >>> FRAC) - uX;
      du      = (IW'(a_q[runIdx_q]) * bvs) >>> FRAC;
      if (spkNow) begin
         vNext = c_q[runIdx_q];
         uNext = sat(uX + IW'(d_q[runIdx_q]));
      end else begin
         vNext = sat(vX + dv);
         uNext = sat(uX + du);
      end
      spikeNext            = spikePend_q;
      spikeNext[runIdx_q]  = spkNow;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         runIdx_q    <= '0;
         stim_q      <= '0;
         mask_q      <= '0;
         spikePend_q <= '0;
         spike_vec_q <= '0;
         overrun_q   <= 1'b0;
         mon_v_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            v_q[i] <= V_REST;
            u_q[i] <= '0;
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= '0;
            d_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         mon_v_q <= vMon[mon_sel_i];
         if (tick_i && (state_q != IDLE)) overrun_q <= 1'b1;
         if (tickAccept) stim_q <= stim_i;
         if (cfgWrite) begin
            mask_q[cfg_idx_i][cfg_sel_i] <= 1'b1;
            case (cfg_sel_i)
               2'd0:    a_q[cfg_idx_i] <= cfg_data_i;
               2'd1:    b_q[cfg_idx_i] <= cfg_data_i;
               2'd2:    c_q[cfg_idx_i] <= cfg_data_i;
               default: d_q[cfg_idx_i] <= cfg_data_i;
            endcase
         end
         if (state_q == RUN) begin
            v_q[runIdx_q] <= vNext;
            u_q[runIdx_q] <= uNext;
            spikePend_q   <= spikeNext;
            if (lastIdx) begin
               runIdx_q    <= '0;
               spike_vec_q <= spikeNext[N_NEURONS-1:0];
            end else begin
               runIdx_q <= runIdx_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_iz_neuron_array.sv
// Randomized bench for iz_neuron_array, compared against a plain-arithmetic neuron model.
module tb_iz_neuron_array;

   localparam int N      = 4;
   localparam int DATA_W = 16;
   localparam int STIM_W = 8;
   localparam int IDX_W  = 2;
   localparam longint VTH   = 30 * 64;
   localparam longint VREST = -70 * 64;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   enable_i = 1'b1;
   logic                   tick_i = 1'b0;
   logic [N*STIM_W-1:0]    stim_i = '0;
   logic                   cfg_valid_i = 1'b0;
   logic                   cfg_ready_o;
   logic [IDX_W-1:0]       cfg_idx_i = '0;
   logic [1:0]             cfg_sel_i = '0;
   logic [DATA_W-1:0]      cfg_data_i = '0;
   logic                   params_ready_o;
   logic                   busy_o;
   logic                   step_done_o;
   logic [N-1:0]           spike_vec_o;
   logic [IDX_W-1:0]       mon_sel_i = '0;
   logic [DATA_W-1:0]      mon_v_o;
   logic                   overrun_o;

   int errors = 0;
   int checks = 0;

   longint mv [N];
   longint mu [N];
   longint prm [N][4];
   logic [N-1:0] mspk;

   iz_neuron_array dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable_i), .tick_i(tick_i), .stim_i(stim_i),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
      .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i), .params_ready_o(params_ready_o),
      .busy_o(busy_o), .step_done_o(step_done_o), .spike_vec_o(spike_vec_o),
      .mon_sel_i(mon_sel_i), .mon_v_o(mon_v_o), .overrun_o(overrun_o)
   );

   always #5 clk = ~clk;

   function automatic longint sat16(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // Reference: textbook update equations on 64-bit integers, all neurons from pre-step values.
   task automatic modelStep(input logic [N*STIM_W-1:0] st);
      longint v, u, s, dv, du;
      for (int i = 0; i < N; i++) begin
         v = mv[i];
         u = mu[i];
         s = longint'(st[i*STIM_W +: STIM_W]);
         if (v >= VTH) begin
            mv[i] = prm[i][2];
            mu[i] = sat16(u + prm[i][3]);
            mspk[i] = 1'b1;
         end else begin
            dv = 3 * ((v * v) >>> 10) + 5 * v + 140 * 64 - u + s * 64;
            du = (prm[i][0] * (((prm[i][1] * v) >>> 6) - u)) >>> 6;
            mv[i] = sat16(v + dv);
            mu[i] = sat16(u + du);
            mspk[i] = 1'b0;
         end
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mv[i] = VREST;
         mu[i] = 0;
         for (int j = 0; j < 4; j++) prm[i][j] = 0;
      end
      mspk = '0;
   endtask

   task automatic cfgWrite(input int idx, input int sel, input longint data);
      @(negedge clk);
      cfg_valid_i = 1'b1;
      cfg_idx_i   = IDX_W'(idx);
      cfg_sel_i   = 2'(sel);
      cfg_data_i  = DATA_W'(data);
      @(posedge clk);
      #1;
      cfg_valid_i = 1'b0;
      prm[idx][sel] = data;
   endtask

   task automatic sampleV(input int idx, output longint val);
      @(negedge clk);
      mon_sel_i = IDX_W'(idx);
      @(posedge clk);
      #1;
      val = longint'($signed(mon_v_o));
   endtask

   // Launches one step; lat counts cycles from the tick cycle (0) to the first step_done cycle.
   task automatic runStep(input logic [N*STIM_W-1:0] st, input bit dropEn, input bit withCfg,
                          input int cIdx, input int cSel, input longint cData, output int lat);
      @(negedge clk);
      stim_i = st;
      tick_i = 1'b1;
      if (withCfg) begin
         cfg_valid_i = 1'b1;
         cfg_idx_i   = IDX_W'(cIdx);
         cfg_sel_i   = 2'(cSel);
         cfg_data_i  = DATA_W'(cData);
      end
      @(posedge clk);
      #1;
      tick_i      = 1'b0;
      cfg_valid_i = 1'b0;
      stim_i      = $urandom;
      lat = 1;
      while (step_done_o !== 1'b1 && lat < 40) begin
         if (dropEn && lat == 2) enable_i = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      enable_i = 1'b1;
   endtask

   task automatic test_reset();
      longint v;
      rst_n = 1'b0;
      #12;
      checks++;
      if ({cfg_ready_o, params_ready_o, busy_o, step_done_o, overrun_o} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want 10000",
                  {cfg_ready_o, params_ready_o, busy_o, step_done_o, overrun_o});
      end
      checks++;
      if (spike_vec_o !== '0 || mon_v_o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_out spike=%b mon=%0d want 0/0", spike_vec_o, mon_v_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      sampleV(2, v);
      checks++;
      if (v !== VREST) begin
         errors++;
         $display("[TB] FAIL reset_v got %0d want %0d", v, VREST);
      end
      @(negedge clk);
      tick_i = 1'b1;
      @(posedge clk);
      #1;
      tick_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tick_unconfigured busy=%b want 0", busy_o);
      end
   endtask

   task automatic test_config();
      cfgWrite(0, 0, 1);
      for (int i = 0; i < N; i++) begin
         for (int s = 0; s < 4; s++) begin
            checks++;
            if (params_ready_o !== 1'b0) begin
               errors++;
               $display("[TB] FAIL params_early idx=%0d sel=%0d got %b want 0", i, s, params_ready_o);
            end
            cfgWrite(i, s, (s == 0) ? 1 : (s == 1) ? 13 : (s == 2) ? -4160 : 512);
         end
      end
      checks++;
      if (params_ready_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL params_ready got %b want 1", params_ready_o);
      end
   endtask

   task automatic test_step_timing();
      int lat;
      longint v;
      runStep('0, 1'b0, 1'b0, 0, 0, 0, lat);
      modelStep('0);
      checks++;
      if (lat !== N + 1) begin
         errors++;
         $display("[TB] FAIL step_latency got %0d want %0d", lat, N + 1);
      end
      checks++;
      if (spike_vec_o !== mspk) begin
         errors++;
         $display("[TB] FAIL step_spikes got %b want %b", spike_vec_o, mspk);
      end
      @(posedge clk);
      #1;
      checks++;
      if (step_done_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_pulse done=%b busy=%b want 0/0", step_done_o, busy_o);
      end
      for (int i = 0; i < N; i++) begin
         sampleV(i, v);
         checks++;
         if (v !== mv[i]) begin
            errors++;
            $display("[TB] FAIL step_v[%0d] got %0d want %0d", i, v, mv[i]);
         end
      end
      checks++;
      if (v !== 32767) begin
         errors++;
         $display("[TB] FAIL sat_pos got %0d want 32767", v);
      end
   endtask

   task automatic test_spike();
      int lat;
      longint v;
      logic [N*STIM_W-1:0] st;
      for (int k = 0; k < 3; k++) begin
         st = '0;
         st[1*STIM_W +: STIM_W] = 8'd255;
         runStep(st, 1'b0, 1'b0, 0, 0, 0, lat);
         modelStep(st);
         checks++;
         if (lat !== N + 1 || spike_vec_o !== mspk) begin
            errors++;
            $display("[TB] FAIL spike_step%0d lat=%0d spikes=%b want lat=%0d spikes=%b",
                     k, lat, spike_vec_o, N + 1, mspk);
         end
         for (int i = 0; i < N; i++) begin
            sampleV(i, v);
            checks++;
            if (v !== mv[i]) begin
               errors++;
               $display("[TB] FAIL spike_v[%0d] step%0d got %0d want %0d", i, k, v, mv[i]);
            end
         end
      end
   endtask

   task automatic test_overrun();
      int dones;
      longint v;
      logic [N*STIM_W-1:0] st;
      st = $urandom;
      dones = 0;
      @(negedge clk);
      stim_i = st;
      tick_i = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid_i = 1'b1;
      cfg_idx_i   = '0;
      cfg_sel_i   = 2'd2;
      cfg_data_i  = DATA_W'(1234);
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (cfg_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_ready_busy got %b want 0", cfg_ready_o);
         end
         @(posedge clk);
         #1;
      end
      tick_i      = 1'b0;
      cfg_valid_i = 1'b0;
      modelStep(st);
      for (int c = 0; c < 3 * N; c++) begin
         if (step_done_o === 1'b1) dones++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (overrun_o !== 1'b1 || dones !== 1) begin
         errors++;
         $display("[TB] FAIL overrun flag=%b dones=%0d want 1/1", overrun_o, dones);
      end
      checks++;
      if (spike_vec_o !== mspk) begin
         errors++;
         $display("[TB] FAIL overrun_spikes got %b want %b", spike_vec_o, mspk);
      end
      for (int i = 0; i < N; i++) begin
         sampleV(i, v);
         checks++;
         if (v !== mv[i]) begin
            errors++;
            $display("[TB] FAIL overrun_v[%0d] got %0d want %0d", i, v, mv[i]);
         end
      end
   endtask

   task automatic test_enable();
      int lat;
      int seen;
      logic [N*STIM_W-1:0] st;
      seen = 0;
      @(negedge clk);
      enable_i = 1'b0;
      tick_i   = 1'b1;
      @(posedge clk);
      #1;
      tick_i = 1'b0;
      for (int c = 0; c < N + 3; c++) begin
         if (busy_o === 1'b1 || step_done_o === 1'b1) seen++;
         @(posedge clk);
         #1;
      end
      enable_i = 1'b1;
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("[TB] FAIL enable_gate active_cycles=%0d want 0", seen);
      end
      st = $urandom;
      runStep(st, 1'b1, 1'b0, 0, 0, 0, lat);
      modelStep(st);
      checks++;
      if (lat !== N + 1 || spike_vec_o !== mspk) begin
         errors++;
         $display("[TB] FAIL enable_drop lat=%0d spikes=%b want lat=%0d spikes=%b",
                  lat, spike_vec_o, N + 1, mspk);
      end
   endtask

   task automatic test_random();
      int lat;
      int ci, cs;
      longint cd, v;
      logic [N*STIM_W-1:0] st;
      for (int k = 0; k < 8; k++) begin
         ci = $urandom_range(N - 1);
         cs = $urandom_range(3);
         case (cs)
            0:       cd = $urandom_range(3);
            1:       cd = $urandom_range(31);
            2:       cd = longint'($urandom_range(6900)) - 5000;
            default: cd = $urandom_range(1000);
         endcase
         st = $urandom;
         if (k % 2 == 0) begin
            cfgWrite(ci, cs, cd);
            runStep(st, 1'b0, 1'b0, 0, 0, 0, lat);
         end else begin
            prm[ci][cs] = cd;
            runStep(st, 1'b0, 1'b1, ci, cs, cd, lat);
         end
         modelStep(st);
         checks++;
         if (lat !== N + 1 || spike_vec_o !== mspk) begin
            errors++;
            $display("[TB] FAIL rand_step%0d lat=%0d spikes=%b want lat=%0d spikes=%b",
                     k, lat, spike_vec_o, N + 1, mspk);
         end
         for (int i = 0; i < N; i++) begin
            sampleV(i, v);
            checks++;
            if (v !== mv[i]) begin
               errors++;
               $display("[TB] FAIL rand_v[%0d] step%0d got %0d want %0d", i, k, v, mv[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int dones;
      longint v;
      dones = 0;
      @(negedge clk);
      tick_i = 1'b1;
      @(posedge clk);
      #1;
      tick_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cfg_ready_o, params_ready_o, busy_o, step_done_o, overrun_o} !== 5'b10000 ||
          spike_vec_o !== '0 || mon_v_o !== '0) begin
         errors++;
         $display("[TB] FAIL midrun_reset flags=%b spike=%b mon=%0d want 10000/0/0",
                  {cfg_ready_o, params_ready_o, busy_o, step_done_o, overrun_o}, spike_vec_o, mon_v_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      for (int c = 0; c < N + 3; c++) begin
         @(posedge clk);
         #1;
         if (step_done_o === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0 || params_ready_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrun_after dones=%0d params_ready=%b want 0/0", dones, params_ready_o);
      end
      sampleV(1, v);
      checks++;
      if (v !== VREST) begin
         errors++;
         $display("[TB] FAIL midrun_v got %0d want %0d", v, VREST);
      end
   endtask

   initial begin
      test_reset();
      test_config();
      test_step_timing();
      test_spike();
      test_overrun();
      test_enable();
      test_random();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
